// File: rtl/gmii_tx_framer_pkg.sv
// ---------------------------------------------------------------------------
// gmii_tx_framer_pkg
// Shared GMII framing constants and the transmit framer state encoding.
// The receive-side checker imports the same constants (CRC_RESIDUE is the
// value a receiver sees after running the CRC over payload plus FCS,
// expressed in normal bit order).
// ---------------------------------------------------------------------------
package gmii_tx_framer_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_DATA  = 3'd2,
        ST_PAD   = 3'd3,
        ST_FCS   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_IFG   = 3'd6
    } tx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// ---------------------------------------------------------------------------
// crc32_d8
// Combinational IEEE 802.3 CRC-32 update, one byte per call, reflected
// polynomial (LSB-first, matching GMII bit order on the wire).
// Ports:
//   i_crc  [31:0]  current CRC register (not inverted)
//   i_data [7:0]   byte to fold in
//   o_crc  [31:0]  CRC register after the byte
// ---------------------------------------------------------------------------
module crc32_d8
    import gmii_tx_framer_pkg::*;
(
    input  logic [31:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [31:0] o_crc
);

    logic [31:0] w_c;

    always_comb begin
        w_c = i_crc ^ {24'h000000, i_data};
        for (int i = 0; i < 8; i++) begin
            w_c = w_c[0] ? ((w_c >> 1) ^ CRC_POLY) : (w_c >> 1);
        end
        o_crc = w_c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// gmii_tx_framer
// GMII transmit framer: preamble + SFD, payload pass-through, zero padding
// to MIN_FRAME, FCS append and inter-frame gap. One instance per PHY, all
// logic in the 125 MHz transmit clock domain.
// Ports:
//   clk_125, reset_n            GMII tx clock, async active-low reset
//   in_data/valid/last/err      payload byte stream (dest MAC .. payload end)
//   in_ready                    byte accepted this cycle (state decode only)
//   gm_txd/gm_tx_en/gm_tx_er    registered GMII pins
//   tx_busy                     any state other than IDLE
//   frame_done                  pulse with the last FCS byte on gm_txd
//   underrun                    pulse with the error byte of an aborted frame
// The FSM decides each cycle what goes on the wire in the *next* cycle, so
// every GMII output is a plain register and the wire stays gapless.
// ---------------------------------------------------------------------------
module gmii_tx_framer
    import gmii_tx_framer_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_FRAME    = 60,
    parameter int IFG_BYTES    = 12
)(
    input  logic       clk_125,
    input  logic       reset_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    input  logic       in_err,
    output logic       in_ready,
    output logic [7:0] gm_txd,
    output logic       gm_tx_en,
    output logic       gm_tx_er,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underrun
);

    localparam logic [15:0] PRE_LAST = 16'(PREAMBLE_LEN);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
    localparam logic [15:0] IFG_LAST = (IFG_BYTES > 0) ? 16'(IFG_BYTES - 1) : 16'd0;

    tx_state_e   r_state, w_state_n;
    logic [15:0] r_cnt, w_cnt_n;      // preamble / FCS index / IFG counter
    logic [15:0] r_len, w_len_n;      // bytes sent since SFD, saturates at MIN_LEN
    logic [31:0] r_crc, w_crc_n;
    logic [31:0] w_crc_fold;
    logic [31:0] w_fcs;
    logic [16:0] w_len_inc;
    logic [7:0]  w_crc_byte;
    logic [7:0]  w_txd_n;
    logic        w_en_n, w_er_n, w_done_n, w_urun_n;

    // Pad bytes are zeros; everything else folded is the accepted input byte.
    assign w_crc_byte = (r_state == ST_PAD) ? 8'h00 : in_data;

    crc32_d8 u_crc (
        .i_crc  (r_crc),
        .i_data (w_crc_byte),
        .o_crc  (w_crc_fold)
    );

    assign in_ready  = (r_state == ST_DATA) || (r_state == ST_DRAIN);
    assign tx_busy   = (r_state != ST_IDLE);
    assign w_len_inc = {1'b0, r_len} + 17'd1;
    assign w_fcs     = ~r_crc;

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_len_n   = r_len;
        w_crc_n   = r_crc;
        w_txd_n   = 8'h00;
        w_en_n    = 1'b0;
        w_er_n    = 1'b0;
        w_done_n  = 1'b0;
        w_urun_n  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                // First preamble byte goes out on the very next cycle.
                if (in_valid) begin
                    w_state_n = ST_PRE;
                    w_txd_n   = PREAMBLE_BYTE;
                    w_en_n    = 1'b1;
                    w_cnt_n   = 16'd1;
                    w_len_n   = 16'd0;
                    w_crc_n   = CRC_INIT;
                end
            end

            ST_PRE: begin
                w_en_n = 1'b1;
                if (r_cnt < PRE_LAST) begin
                    w_txd_n = PREAMBLE_BYTE;
                    w_cnt_n = r_cnt + 16'd1;
                end else begin
                    w_txd_n   = SFD_BYTE;
                    w_state_n = ST_DATA;
                end
            end

            ST_DATA: begin
                w_en_n = 1'b1;
                if (in_valid) begin
                    w_txd_n = in_data;
                    w_er_n  = in_err;
                    w_crc_n = w_crc_fold;
                    if (r_len < MIN_LEN) begin
                        w_len_n = w_len_inc[15:0];
                    end
                    if (in_last) begin
                        w_cnt_n   = 16'd0;
                        w_state_n = (w_len_inc < {1'b0, MIN_LEN}) ? ST_PAD : ST_FCS;
                    end
                end else begin
                    // Source starved mid-frame: poison the frame and abandon it.
                    w_er_n    = 1'b1;
                    w_urun_n  = 1'b1;
                    w_state_n = ST_DRAIN;
                end
            end

            ST_PAD: begin
                w_en_n  = 1'b1;
                w_crc_n = w_crc_fold;
                w_len_n = w_len_inc[15:0];
                if (w_len_inc >= {1'b0, MIN_LEN}) begin
                    w_cnt_n   = 16'd0;
                    w_state_n = ST_FCS;
                end
            end

            ST_FCS: begin
                w_en_n  = 1'b1;
                w_txd_n = w_fcs[{r_cnt[1:0], 3'b000} +: 8];
                w_cnt_n = r_cnt + 16'd1;
                if (r_cnt[1:0] == 2'd3) begin
                    w_done_n  = 1'b1;
                    w_cnt_n   = 16'd0;
                    w_state_n = ST_IFG;
                end
            end

            ST_DRAIN: begin
                if (in_valid && in_last) begin
                    w_cnt_n   = 16'd0;
                    w_state_n = ST_IFG;
                end
            end

            ST_IFG: begin
                if (r_cnt >= IFG_LAST) begin
                    w_state_n = ST_IDLE;
                end else begin
                    w_cnt_n = r_cnt + 16'd1;
                end
            end

            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_125 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 16'd0;
            r_len      <= 16'd0;
            r_crc      <= 32'd0;
            gm_txd     <= 8'h00;
            gm_tx_en   <= 1'b0;
            gm_tx_er   <= 1'b0;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_len      <= w_len_n;
            r_crc      <= w_crc_n;
            gm_txd     <= w_txd_n;
            gm_tx_en   <= w_en_n;
            gm_tx_er   <= w_er_n;
            frame_done <= w_done_n;
            underrun   <= w_urun_n;
        end
    end

endmodule

// File: tb/tb_gmii_tx_framer.sv
// ---------------------------------------------------------------------------
// tb_gmii_tx_framer
// Scoreboard bench: each scenario pushes the expected wire bytes when it
// drives a frame; a negedge monitor pops and compares every gm_tx_en byte.
// A second framer instance with MIN_FRAME=0 shares the inputs for the
// unpadded reference-vector check.
// ---------------------------------------------------------------------------
module tb_gmii_tx_framer;

    localparam int MIN_FRAME = 60;

    typedef struct packed {
        logic [7:0] txd;
        logic       er;
        logic       done;
        logic       ur;
    } exp_t;

    logic       clk_125 = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_err = 1'b0;
    logic       in_ready, gm_tx_en, gm_tx_er, tx_busy, frame_done, underrun;
    logic [7:0] gm_txd;
    logic       u0_ready, u0_en, u0_er, u0_busy, u0_done, u0_ur;
    logic [7:0] u0_txd;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t       exp_q[$];
    logic [7:0] cap[$];
    logic [8:0] cap0[$];
    bit         sb_on = 1'b1;
    int         en_cnt = 0, done_cnt = 0, ur_cnt = 0;
    bit         in_gap = 1'b0;
    int         idle_run = 0, last_gap = -1, rdy_in_gap = 0;

    always #4 clk_125 = ~clk_125;

    gmii_tx_framer dut (
        .clk_125(clk_125), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_err(in_err), .in_ready(in_ready), .gm_txd(gm_txd),
        .gm_tx_en(gm_tx_en), .gm_tx_er(gm_tx_er), .tx_busy(tx_busy),
        .frame_done(frame_done), .underrun(underrun)
    );

    gmii_tx_framer #(.MIN_FRAME(0)) u0 (
        .clk_125(clk_125), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_err(in_err), .in_ready(u0_ready), .gm_txd(u0_txd),
        .gm_tx_en(u0_en), .gm_tx_er(u0_er), .tx_busy(u0_busy),
        .frame_done(u0_done), .underrun(u0_ur)
    );

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // Monitor / scoreboard
    always @(negedge clk_125) begin
        exp_t e, got;
        if (reset_n) begin
            if (gm_tx_en) begin
                en_cnt++;
                cap.push_back(gm_txd);
                if (in_gap) begin
                    last_gap = idle_run;
                    in_gap = 1'b0;
                end
                if (sb_on) begin
                    n_checks++;
                    got = '{gm_txd, gm_tx_er, frame_done, underrun};
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL sb_extra_byte: got txd=%02h er=%0b, expected no byte", gm_txd, gm_tx_er);
                    end else begin
                        e = exp_q.pop_front();
                        if (got !== e) begin
                            n_fail++;
                            $display("FAIL sb_byte: got txd=%02h er=%0b done=%0b ur=%0b, expected txd=%02h er=%0b done=%0b ur=%0b",
                                     got.txd, got.er, got.done, got.ur, e.txd, e.er, e.done, e.ur);
                        end
                    end
                end
            end else begin
                if (in_gap) begin
                    idle_run++;
                    if (in_ready) rdy_in_gap++;
                end
                if (sb_on) begin
                    n_checks++;
                    if (frame_done || underrun) begin
                        n_fail++;
                        $display("FAIL idle_pulse: got done=%0b ur=%0b with tx_en=0, expected 0 0", frame_done, underrun);
                    end
                end
            end
            if (frame_done) begin
                in_gap = 1'b1;
                idle_run = 0;
                done_cnt++;
            end
            if (underrun) ur_cnt++;
            if (u0_en) cap0.push_back({u0_txd, u0_done});
        end
    end

    task automatic push_frame(input logic [7:0] pl[$], input int err_idx, input int ur_idx, input int min_len);
        logic [31:0] c;
        int n;
        for (int i = 0; i < 7; i++) exp_q.push_back('{8'h55, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{8'hD5, 1'b0, 1'b0, 1'b0});
        c = 32'hFFFFFFFF;
        for (int i = 0; i < pl.size(); i++) begin
            if (i == ur_idx) begin
                exp_q.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
                return;
            end
            exp_q.push_back('{pl[i], 1'(i == err_idx), 1'b0, 1'b0});
            c = crc8(c, pl[i]);
        end
        n = pl.size();
        while (n < min_len) begin
            exp_q.push_back('{8'h00, 1'b0, 1'b0, 1'b0});
            c = crc8(c, 8'h00);
            n++;
        end
        c = ~c;
        for (int k = 0; k < 4; k++) exp_q.push_back('{c[8*k +: 8], 1'b0, 1'(k == 3), 1'b0});
    endtask

    task automatic drive_frame(input logic [7:0] pl[$], input int err_idx, input int gap_idx,
                               input bit keep, output bit ok);
        int i, n, guard;
        bit gapped, acc;
        n = pl.size(); i = 0; guard = 0; gapped = 0;
        in_valid = 1'b1; in_data = pl[0]; in_last = (n == 1); in_err = (err_idx == 0);
        while (i < n && guard < 4000) begin
            @(negedge clk_125);
            acc = in_ready && in_valid;
            @(posedge clk_125); #1;
            guard++;
            if (acc) i++;
            if (i < n) begin
                if (i == gap_idx && !gapped) begin
                    in_valid = 1'b0;
                    gapped = 1'b1;
                end else begin
                    in_valid = 1'b1; in_data = pl[i]; in_last = (i == n - 1); in_err = (i == err_idx);
                end
            end
        end
        ok = (i == n);
        if (!keep) begin
            in_valid = 1'b0; in_last = 1'b0; in_err = 1'b0;
        end
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_125); #1;
            if (exp_q.size() == 0 && !tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk_125); #1;
    endtask

    task automatic make_pl(input int n, input int seed, output logic [7:0] pl[$]);
        pl.delete();
        for (int i = 0; i < n; i++) pl.push_back(8'((i * 37 + seed) & 8'hFF));
    endtask

    task automatic test_reset();
        #21;
        n_checks++;
        if ({gm_txd, gm_tx_en, gm_tx_er, in_ready, tx_busy, frame_done, underrun} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_main: got %04h, expected 0000",
                     {gm_txd, gm_tx_en, gm_tx_er, in_ready, tx_busy, frame_done, underrun});
        end
        n_checks++;
        if ({u0_txd, u0_en, u0_er, u0_ready, u0_busy, u0_done, u0_ur} !== 14'h0) begin
            n_fail++;
            $display("FAIL reset_u0: got %04h, expected 0000",
                     {u0_txd, u0_en, u0_er, u0_ready, u0_busy, u0_done, u0_ur});
        end
        @(negedge clk_125); reset_n = 1'b1;
        @(posedge clk_125); #1;
    endtask

    task automatic test_nopad();
        logic [7:0] pl[$];
        logic [7:0] ref0 [21] = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5,
                                  8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                                  8'h26, 8'h39, 8'hF4, 8'hCB};
        bit ok;
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'h31 + 8'(i));
        cap0.delete();
        push_frame(pl, -1, -1, MIN_FRAME);
        drive_frame(pl, -1, -1, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nopad_drive: got timeout, expected all bytes accepted"); end
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL nopad_idle: got timeout, expected idle"); end
        n_checks++;
        if (cap0.size() != 21) begin
            n_fail++;
            $display("FAIL nopad_len: got %0d tx_en cycles, expected 21", cap0.size());
        end
        for (int i = 0; i < 21 && i < cap0.size(); i++) begin
            n_checks++;
            if (cap0[i] !== {ref0[i], 1'(i == 20)}) begin
                n_fail++;
                $display("FAIL nopad_byte%0d: got txd=%02h done=%0b, expected txd=%02h done=%0b",
                         i, cap0[i][8:1], cap0[i][0], ref0[i], (i == 20));
            end
        end
    endtask

    task automatic test_pad();
        logic [7:0] pl[$];
        logic [31:0] r, rev;
        bit ok;
        int d0;
        make_pl(14, 5, pl);
        cap.delete();
        d0 = done_cnt;
        push_frame(pl, -1, -1, MIN_FRAME);
        drive_frame(pl, -1, -1, 1'b0, ok);
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL pad_idle: got timeout, expected idle"); end
        n_checks++;
        if (cap.size() != 72) begin
            n_fail++;
            $display("FAIL pad_len: got %0d bytes, expected 72", cap.size());
        end else begin
            // Receiver view: CRC over 60 data bytes + 4 FCS bytes; the reflected
            // register, bit-reversed, is the normal-order 802.3 residue.
            r = 32'hFFFFFFFF;
            for (int i = 8; i < 72; i++) r = crc8(r, cap[i]);
            for (int b = 0; b < 32; b++) rev[b] = r[31 - b];
            n_checks++;
            if (rev !== 32'hC704DD7B) begin
                n_fail++;
                $display("FAIL pad_residue: got %08h, expected c704dd7b", rev);
            end
        end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL pad_done: got %0d pulses, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_err();
        logic [7:0] pl[$];
        bit ok;
        int d0;
        make_pl(20, 11, pl);
        d0 = done_cnt;
        push_frame(pl, 5, -1, MIN_FRAME);
        drive_frame(pl, 5, -1, 1'b0, ok);
        wait_idle(ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL err_idle: got timeout, expected idle"); end
        n_checks++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL err_done: got %0d pulses, expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] p1[$], p2[$];
        bit ok1, ok2, ok3;
        make_pl(64, 1, p1);
        make_pl(64, 99, p2);
        push_frame(p1, -1, -1, MIN_FRAME);
        push_frame(p2, -1, -1, MIN_FRAME);
        in_gap = 1'b0; rdy_in_gap = 0; last_gap = -1;
        drive_frame(p1, -1, -1, 1'b1, ok1);
        drive_frame(p2, -1, -1, 1'b0, ok2);
        wait_idle(ok3);
        n_checks++;
        if (!(ok1 && ok2 && ok3)) begin
            n_fail++;
            $display("FAIL b2b_timeout: got %0b%0b%0b, expected 111", ok1, ok2, ok3);
        end
        n_checks++;
        if (last_gap != 12) begin
            n_fail++;
            $display("FAIL b2b_ifg: got %0d idle cycles, expected 12", last_gap);
        end
        n_checks++;
        if (rdy_in_gap != 0) begin
            n_fail++;
            $display("FAIL b2b_ready_in_ifg: got %0d cycles with in_ready=1, expected 0", rdy_in_gap);
        end
    endtask

    task automatic test_underrun();
        logic [7:0] pl[$], p2[$];
        bit ok;
        int d0, u0c;
        make_pl(30, 7, pl);
        d0 = done_cnt; u0c = ur_cnt;
        push_frame(pl, -1, 20, MIN_FRAME);
        drive_frame(pl, -1, 20, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ur_drain: got timeout, expected all bytes consumed"); end
        wait_idle(ok);
        n_checks++;
        if (ur_cnt - u0c != 1 || done_cnt - d0 != 0) begin
            n_fail++;
            $display("FAIL ur_pulses: got ur=%0d done=%0d, expected ur=1 done=0", ur_cnt - u0c, done_cnt - d0);
        end
        make_pl(16, 44, p2);
        push_frame(p2, -1, -1, MIN_FRAME);
        drive_frame(p2, -1, -1, 1'b0, ok);
        wait_idle(ok);
        n_checks++;
        if (done_cnt - d0 != 1 || ur_cnt - u0c != 1) begin
            n_fail++;
            $display("FAIL ur_next_frame: got done=%0d ur=%0d, expected done=1 ur=1", done_cnt - d0, ur_cnt - u0c);
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] pl[$];
        logic [31:0] c;
        bit ok, hit;
        int base;
        make_pl(14, 77, pl);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 14; i++) c = crc8(c, pl[i]);
        for (int i = 14; i < MIN_FRAME; i++) c = crc8(c, 8'h00);
        c = ~c;
        sb_on = 1'b0;
        base = en_cnt;
        drive_frame(pl, -1, -1, 1'b0, ok);
        hit = 1'b0;
        // 8 preamble/SFD + 60 data + 2 FCS: the 70th enabled byte is FCS byte 2.
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_125); #1;
            if (en_cnt - base == 70) begin hit = 1'b1; break; end
        end
        n_checks++;
        if (!hit || gm_txd !== c[15:8] || gm_tx_en !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_fcs2: got en=%0b txd=%02h, expected en=1 txd=%02h", gm_tx_en, gm_txd, c[15:8]);
        end
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({gm_txd, gm_tx_en, gm_tx_er, in_ready, tx_busy, frame_done} !== 13'h0) begin
            n_fail++;
            $display("FAIL rst_async: got %04h, expected 0000",
                     {gm_txd, gm_tx_en, gm_tx_er, in_ready, tx_busy, frame_done});
        end
        exp_q.delete();
        repeat (3) @(posedge clk_125);
        @(negedge clk_125); reset_n = 1'b1;
        sb_on = 1'b1;
        @(posedge clk_125); #1;
    endtask

    task automatic test_after_reset();
        logic [7:0] pl[$];
        bit ok;
        int d0;
        make_pl(20, 200, pl);
        d0 = done_cnt;
        push_frame(pl, -1, -1, MIN_FRAME);
        in_valid = 1'b1; in_data = pl[0]; in_last = 1'b0; in_err = 1'b0;
        @(negedge clk_125); #1;
        n_checks++;
        if (gm_tx_en !== 1'b0) begin
            n_fail++;
            $display("FAIL lat_before: got en=%0b, expected 0", gm_tx_en);
        end
        @(negedge clk_125); #1;
        n_checks++;
        if (gm_tx_en !== 1'b1 || gm_txd !== 8'h55) begin
            n_fail++;
            $display("FAIL lat_first: got en=%0b txd=%02h, expected en=1 txd=55", gm_tx_en, gm_txd);
        end
        drive_frame(pl, -1, -1, 1'b0, ok);
        wait_idle(ok);
        n_checks++;
        if (!ok || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL post_reset_frame: got ok=%0b done=%0d, expected ok=1 done=1", ok, done_cnt - d0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_nopad();
        test_pad();
        test_err();
        test_back_to_back();
        test_underrun();
        test_reset_midframe();
        test_after_reset();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d pending bytes, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
